// File: rtl/cnt_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : cnt_run_ctrl_if
// Brief   : Command/status bundle between the run controller and its user.
// Revision: 1.0  initial release
// ============================================================================
interface cnt_run_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             up;
   logic             wrap;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic             cnt_en;
   logic             busy;
   logic             done;
   logic [1:0]       state;

   modport master (
      output start, stop, clear, load, load_val, up, wrap, limit,
      input  count, cnt_en, busy, done, state
   );

   modport slave (
      input  start, stop, clear, load, load_val, up, wrap, limit,
      output count, cnt_en, busy, done, state
   );
endinterface
`default_nettype wire

// File: rtl/cnt_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cnt_run_ctrl
// Brief   : Single-clock run-control sequencer for the display/sync counter.
// Revision: 1.0  initial release
// ============================================================================
module cnt_run_ctrl #(
   parameter int WIDTH = 4,
   parameter int DIV   = 500
) (
   input  logic           clk,
   input  logic           rst,
   cnt_run_ctrl_if.slave  bus
);

   localparam int               c_PW      = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [c_PW-1:0]  c_TICK_AT = c_PW'(DIV - 1);
   localparam logic [c_PW-1:0]  c_P_ONE   = c_PW'(1);
   localparam logic [c_PW-1:0]  c_P_ZERO  = '0;
   localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_ZERO    = '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [c_PW-1:0]  r_presc;
   logic             r_cnt_en;
   logic             r_done;

   state_t           w_state;
   logic [WIDTH-1:0] w_count;
   logic [c_PW-1:0]  w_presc;
   logic             w_cnt_en;
   logic             w_done;
   logic             w_tick;
   logic             w_at_term;

   assign w_tick    = (r_presc == c_TICK_AT);
   // Up-count uses >= so a loaded value above limit still terminates.
   assign w_at_term = bus.up ? (r_count >= bus.limit) : (r_count == c_ZERO);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_count  <= c_ZERO;
         r_presc  <= c_P_ZERO;
         r_cnt_en <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_count  <= w_count;
         r_presc  <= w_presc;
         r_cnt_en <= w_cnt_en;
         r_done   <= w_done;
      end
   end

   always_comb begin
      w_state  = r_state;
      w_count  = r_count;
      w_presc  = r_presc;
      w_cnt_en = 1'b0;
      w_done   = 1'b0;

      if (bus.clear) begin
         w_state = ST_IDLE;
         w_count = c_ZERO;
         w_presc = c_P_ZERO;
      end else if (bus.load && (r_state != ST_RUN)) begin
         w_count = bus.load_val;
         w_presc = c_P_ZERO;
         if (r_state == ST_DONE) begin
            w_state = ST_IDLE;
         end
      end else if (r_state == ST_RUN) begin
         // An asserted (but ignored) load still masks stop.
         if (bus.stop && !bus.load) begin
            w_state = ST_PAUSE;
         end else if (w_tick) begin
            w_presc = c_P_ZERO;
            if (w_at_term && !bus.wrap) begin
               w_state = ST_DONE;
               w_done  = 1'b1;
            end else begin
               w_cnt_en = 1'b1;
               if (w_at_term) begin
                  w_count = bus.up ? c_ZERO : bus.limit;
               end else begin
                  w_count = bus.up ? (r_count + c_ONE) : (r_count - c_ONE);
               end
            end
         end else begin
            w_presc = r_presc + c_P_ONE;
         end
      end else if (bus.start && !bus.stop) begin
         w_state = ST_RUN;
         w_presc = c_P_ZERO;
         if (r_state == ST_DONE) begin
            w_count = bus.up ? c_ZERO : bus.limit;
         end
      end
   end

   assign bus.count  = r_count;
   assign bus.cnt_en = r_cnt_en;
   assign bus.done   = r_done;
   assign bus.busy   = (r_state == ST_RUN) || (r_state == ST_PAUSE);
   assign bus.state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cnt_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cnt_run_ctrl
// Brief   : Directed plus randomized bench for cnt_run_ctrl against a model.
// Revision: 1.0  initial release
// ============================================================================
module tb_cnt_run_ctrl;

   localparam int WIDTH = 4;
   localparam int DIV   = 4;
   localparam int IDLE  = 0;
   localparam int RUN   = 1;
   localparam int PAUSE = 2;
   localparam int DONE  = 3;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   int   m_state;
   int   m_count;
   int   m_run_cycles;
   int   m_cnt_en;
   int   m_done;

   cnt_run_ctrl_if #(.WIDTH(WIDTH)) bus ();

   cnt_run_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_tick();
      int lim;
      lim = int'(bus.limit);
      if (bus.up) begin
         if (m_count >= lim) begin
            if (bus.wrap) begin m_count = 0; m_cnt_en = 1; end
            else begin m_state = DONE; m_done = 1; end
         end else begin
            m_count  = (m_count + 1) % (1 << WIDTH);
            m_cnt_en = 1;
         end
      end else begin
         if (m_count == 0) begin
            if (bus.wrap) begin m_count = lim; m_cnt_en = 1; end
            else begin m_state = DONE; m_done = 1; end
         end else begin
            m_count  = m_count - 1;
            m_cnt_en = 1;
         end
      end
   endfunction

   // Applied at each rising edge using the inputs that were stable before it.
   function automatic void model_step();
      m_cnt_en = 0;
      m_done   = 0;
      if (rst || bus.clear) begin
         m_state = IDLE; m_count = 0; m_run_cycles = 0;
      end else if (bus.load && m_state != RUN) begin
         m_count = int'(bus.load_val);
         m_run_cycles = 0;
         if (m_state == DONE) m_state = IDLE;
      end else if (m_state == RUN) begin
         if (bus.stop && !bus.load) begin
            m_state = PAUSE;
         end else begin
            m_run_cycles = (m_run_cycles + 1) % DIV;
            if (m_run_cycles == 0) model_tick();
         end
      end else if (bus.start && !bus.stop) begin
         if (m_state == DONE) m_count = bus.up ? 0 : int'(bus.limit);
         m_state = RUN;
         m_run_cycles = 0;
      end
   endfunction

   task automatic cyc(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step();
         #1;
         chk({tag, ".state"},  32'(bus.state),  32'(m_state));
         chk({tag, ".count"},  32'(bus.count),  32'(m_count));
         chk({tag, ".cnt_en"}, 32'(bus.cnt_en), 32'(m_cnt_en));
         chk({tag, ".done"},   32'(bus.done),   32'(m_done));
         chk({tag, ".busy"},   32'(bus.busy),   32'((m_state == RUN) || (m_state == PAUSE)));
      end
   endtask

   task automatic pulse_start(input string tag);
      bus.start = 1'b1; cyc(1, tag); bus.start = 1'b0;
   endtask

   task automatic pulse_clear(input string tag);
      bus.clear = 1'b1; cyc(1, tag); bus.clear = 1'b0;
   endtask

   task automatic do_load(input int v, input string tag);
      bus.load_val = WIDTH'(v);
      bus.load = 1'b1; cyc(1, tag); bus.load = 1'b0;
   endtask

   initial begin
      int r;
      n_vec = 0; n_err = 0;
      m_state = 0; m_count = 0; m_run_cycles = 0; m_cnt_en = 0; m_done = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
      bus.load_val = '0; bus.up = 1'b1; bus.wrap = 1'b1; bus.limit = 4'd5;

      cyc(2, "reset");
      rst = 1'b0;
      chk("reset_state", 32'(bus.state), 32'(IDLE));
      chk("reset_count", 32'(bus.count), 32'd0);

      // Up-count with wrap at limit 5.
      pulse_start("up_wrap");
      cyc(24, "up_wrap");
      chk("up_wrap_end", 32'(bus.count), 32'd0);
      cyc(4, "up_wrap");
      pulse_clear("clr1");

      // Up-count to limit 3 then stop in DONE.
      bus.limit = 4'd3; bus.wrap = 1'b0;
      pulse_start("up_stop");
      cyc(16, "up_stop");
      chk("up_stop_state", 32'(bus.state), 32'(DONE));
      chk("up_stop_done",  32'(bus.done),  32'd1);
      chk("up_stop_count", 32'(bus.count), 32'd3);
      cyc(2, "done_hold");
      pulse_start("restart");
      chk("restart_count", 32'(bus.count), 32'd0);
      chk("restart_state", 32'(bus.state), 32'(RUN));
      pulse_clear("clr2");

      // Down-count with reload at limit 9, then down to DONE.
      bus.up = 1'b0; bus.wrap = 1'b1; bus.limit = 4'd9;
      do_load(2, "dn_load");
      pulse_start("dn_wrap");
      cyc(16, "dn_wrap");
      chk("dn_wrap_count", 32'(bus.count), 32'd8);
      pulse_clear("clr3");
      bus.wrap = 1'b0;
      do_load(1, "dn_load2");
      pulse_start("dn_stop");
      cyc(8, "dn_stop");
      chk("dn_stop_state", 32'(bus.state), 32'(DONE));
      chk("dn_stop_count", 32'(bus.count), 32'd0);
      pulse_clear("clr4");

      // Pause and resume.
      bus.up = 1'b1; bus.wrap = 1'b1; bus.limit = 4'd15;
      pulse_start("pause");
      cyc(1, "pause");
      bus.stop = 1'b1; cyc(1, "pause"); bus.stop = 1'b0;
      cyc(10, "paused");
      chk("paused_busy", 32'(bus.busy), 32'd1);
      pulse_start("resume");
      cyc(6, "resume");

      // Priority and ignored load in RUN.
      bus.clear = 1'b1; bus.load = 1'b1; bus.start = 1'b1;
      cyc(1, "prio");
      bus.clear = 1'b0; bus.load = 1'b0; bus.start = 1'b0;
      chk("prio_state", 32'(bus.state), 32'(IDLE));
      pulse_start("ld_run");
      cyc(2, "ld_run");
      do_load(7, "ld_run_ign");
      cyc(4, "ld_run");
      pulse_clear("clr5");
      bus.limit = 4'd5; bus.wrap = 1'b0;
      do_load(12, "over_load");
      pulse_start("over_nowrap");
      cyc(4, "over_nowrap");
      chk("over_nowrap_count", 32'(bus.count), 32'd12);
      pulse_clear("clr6");
      bus.wrap = 1'b1;
      do_load(12, "over_load2");
      pulse_start("over_wrap");
      cyc(4, "over_wrap");

      // Reset one cycle before a tick.
      pulse_clear("clr7");
      pulse_start("rst_mid");
      cyc(2, "rst_mid");
      rst = 1'b1; cyc(1, "rst_mid"); rst = 1'b0;
      chk("rst_mid_state", 32'(bus.state), 32'(IDLE));
      cyc(6, "rst_after");

      // Randomized commands, at most one per cycle.
      for (int k = 0; k < 800; k++) begin
         r = int'($urandom_range(0, 99));
         bus.start = (r < 8);
         bus.stop  = (r >= 8  && r < 11);
         bus.clear = (r >= 11 && r < 13);
         bus.load  = (r >= 13 && r < 16);
         rst       = (r == 16);
         bus.load_val = WIDTH'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) begin
            bus.up    = 1'($urandom_range(0, 1));
            bus.wrap  = 1'($urandom_range(0, 1));
            bus.limit = WIDTH'($urandom_range(0, 15));
         end
         cyc(1, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
